imm_encoder: RTL
================

Name: imm_encoder

Overview:
- Inverse of the core's immediate extender.
- Takes a base instruction word, a 32-bit immediate and a 3-bit format code. Inserts the immediate into that format's instruction bit fields and leaves all other bits unchanged.
- Flags immediates the format cannot represent.
- Two-stage valid/ready pipeline. Used by the instruction-patch path and by the extender round-trip checker.

Parameters:
- CNT_W, 16, width of the saturating error counter (only used when the optional feature is enabled).

Ports:
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_fmt  input  3  format code: 0 I, 1 S (scaled by 4), 2 B, 3 J, 4 U, 5 reserved, 6 C (cache fill), 7 reserved
- in_base  input  32  base instruction word
- in_imm  input  32  immediate to encode
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_inst  output  32  patched instruction
- out_err  output  1  immediate not representable, or format unsupported
- out_fmt  output  3  format code passed through with the result
- err_count  output  CNT_W  saturating error count (only when IMM_ENC_ERR_CNT_EN is defined)

Behaviour:
Field mapping (bits not listed come from in_base):
- I: inst[31:20] = imm[11:0]. Error unless imm[31:11] are all equal.
- S: inst[31:25] = imm[13:7], inst[11:7] = imm[6:2]. Error if imm[1:0] != 0 or imm[31:13] are not all equal.
- B: inst[31] = imm[12], inst[7] = imm[11], inst[30:25] = imm[10:5], inst[11:8] = imm[4:1]. Error if imm[0] != 0 or imm[31:12] are not all equal.
- J: inst[31] = imm[20], inst[30:21] = imm[10:1], inst[20] = imm[11], inst[19:12] = imm[19:12]. Error if imm[0] != 0 or imm[31:20] are not all equal.
- U: inst[31:12] = imm[31:12]. Error if imm[11:0] != 0.
- C: inst[31:20] = imm[19:8], inst[11:7] = imm[7:3], inst[14:12] = imm[2:0]. Error unless imm[31:19] are all equal.
- Formats 5 and 7: out_inst = in_base, out_err = 1.
- On a range error the fields are still written with the truncated bits.

Pipeline and handshake:
- Stage 1 registers the request. Stage 2 registers the encoded result, which drives the outputs.
- Latency is 2 cycles from acceptance to out_valid when the output is not stalled.
- Stage 2 loads when it is empty or out_ready=1. Stage 1 advances under the same condition.
- in_ready = !s1_valid || !s2_valid || out_ready. This gives one result per cycle at full throughput.
- While out_valid && !out_ready, out_inst, out_err and out_fmt hold stable.
- At most 2 requests are in flight; in_ready drops when both stages are full and stalled.
- Order is strictly preserved.

Reset:
- out_valid=0, in_ready=1 (combinationally, since both stages are empty), out_inst=0, out_err=0, out_fmt=0, err_count=0.
- A reset mid-operation discards both stages.
- in_valid is ignored while rst is high.

Round-trip property: for any request with out_err=0, extending out_inst with the same format code returns in_imm exactly.

Optional Feature:
- Macro: IMM_ENC_ERR_CNT_EN.
- Defined: err_count increments by 1 each time a result with out_err=1 is accepted (out_valid && out_ready), and saturates at all ones.
- Not defined: neither the err_count port nor the counter logic exists.

Decomposition:
- Shared package riscv_imm_pkg holds the format code constants (IMM_I=0, IMM_S=1, IMM_B=2, IMM_J=3, IMM_U=4, IMM_C=6) and the per-format 32-bit field masks.
- The extender's case labels switch to the same package constants.
- One combinational sub-module, imm_field_pack (fmt, base, imm -> inst, err), is instantiated in stage 2. The checker reuses it.

Test Plan:
- I: base 0x00000013, imm 0xFFFFF800 -> out_inst 0x80000013, err 0, out_valid 2 cycles after acceptance. Same with imm 0x00000800 -> out_inst 0x80000013, err 1.
- S: base 0x00002023, imm 0x00000004 -> 0x000020A3, err 0. imm 0x00000006 -> err 1.
- B/J: base 0x00000063, imm 0xFFFFFFFE -> 0xFE000FE3. Base 0x0000006F, imm 0x00000800 -> 0x0010006F, both err 0.
- fmt 5, base 0x12345678 -> out_inst 0x12345678, err 1. With IMM_ENC_ERR_CNT_EN, err_count goes 0 -> 1 on acceptance.
- Backpressure: out_ready=0, 3 requests offered -> 2 accepted, then in_ready=0 and out_inst stays stable. Set out_ready=1 -> 3 results in order, one per cycle.
- Reset asserted with 2 requests in flight -> out_valid=0 immediately and in_ready=1 after release. Random fmt/imm sweep -> extend(out_inst) == in_imm whenever err=0.

Source files
------------

// File: rtl/riscv_imm_pkg.sv
// Shared immediate-format definitions for the extender, the encoder and the round-trip checker.
// Format codes, per-format instruction field masks and the request record.
package riscv_imm_pkg;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;
   localparam logic [2:0] IMM_C = 3'd6;

   // Instruction bits that each format overwrites with immediate bits.
   localparam logic [31:0] MASK_I = 32'hFFF0_0000;
   localparam logic [31:0] MASK_S = 32'hFE00_0F80;
   localparam logic [31:0] MASK_B = 32'hFE00_0F80;
   localparam logic [31:0] MASK_J = 32'hFFFF_F000;
   localparam logic [31:0] MASK_U = 32'hFFFF_F000;
   localparam logic [31:0] MASK_C = 32'hFFF0_7F80;

   typedef struct packed {
      logic [2:0]  fmt;
      logic [31:0] base;
      logic [31:0] imm;
   } imm_req_t;

   // True when v[31:lsb] are all equal, i.e. v fits a signed field whose sign bit is lsb.
   function automatic logic upper_uniform(input logic [31:0] v, input int unsigned lsb);
      logic signed [31:0] s;
      s = $signed(v) >>> lsb;
      return (s == '0) || (s == '1);
   endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational immediate packer: scatters imm into the format's instruction fields
// and flags values the format cannot represent; unspecified codes pass base through with err.
module imm_field_pack
   import riscv_imm_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [31:0] base,
   input  logic [31:0] imm,
   output logic [31:0] inst,
   output logic        err
);

   logic [31:0] field;
   logic [31:0] mask;

   always_comb begin
      field = '0;
      mask  = '0;
      err   = 1'b0;
      case (fmt)
         IMM_I: begin
            mask          = MASK_I;
            field[31:20]  = imm[11:0];
            err           = !upper_uniform(imm, 11);
         end
         IMM_S: begin
            mask          = MASK_S;
            field[31:25]  = imm[13:7];
            field[11:7]   = imm[6:2];
            err           = (imm[1:0] != 2'b00) || !upper_uniform(imm, 13);
         end
         IMM_B: begin
            mask          = MASK_B;
            field[31]     = imm[12];
            field[7]      = imm[11];
            field[30:25]  = imm[10:5];
            field[11:8]   = imm[4:1];
            err           = imm[0] || !upper_uniform(imm, 12);
         end
         IMM_J: begin
            mask          = MASK_J;
            field[31]     = imm[20];
            field[30:21]  = imm[10:1];
            field[20]     = imm[11];
            field[19:12]  = imm[19:12];
            err           = imm[0] || !upper_uniform(imm, 20);
         end
         IMM_U: begin
            mask          = MASK_U;
            field[31:12]  = imm[31:12];
            err           = (imm[11:0] != 12'h000);
         end
         IMM_C: begin
            mask          = MASK_C;
            field[31:20]  = imm[19:8];
            field[11:7]   = imm[7:3];
            field[14:12]  = imm[2:0];
            err           = !upper_uniform(imm, 19);
         end
         default: begin
            err = 1'b1;
         end
      endcase
      // Truncated bits are still written on a range error.
      inst = (base & ~mask) | field;
   end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder: stage 1 holds the request, stage 2 the packed result.
// Optional saturating error counter enabled by defining IMM_ENC_ERR_CNT_EN.
module imm_encoder
   import riscv_imm_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_fmt,
   input  logic [31:0]      in_base,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic             out_err,
   output logic [2:0]       out_fmt
`ifdef IMM_ENC_ERR_CNT_EN
   ,
   output logic [CNT_W-1:0] err_count
`endif
);

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   logic        s1_valid_reg;
   imm_req_t    s1_req_reg;
   logic        s2_valid_reg;
   logic [31:0] s2_inst_reg;
   logic        s2_err_reg;
   logic [2:0]  s2_fmt_reg;

   logic        advance;
   logic [31:0] pack_inst;
   logic        pack_err;

   // Stage 2 may load when empty or drained this cycle; stage 1 may also load whenever it is empty.
   assign advance  = !s2_valid_reg || out_ready;
   assign in_ready = !s1_valid_reg || advance;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         s1_req_reg   <= '0;
      end else if (in_ready) begin
         s1_valid_reg <= in_valid;
         if (in_valid) begin
            s1_req_reg <= '{fmt: in_fmt, base: in_base, imm: in_imm};
         end
      end
   end

   imm_field_pack u_pack (
      .fmt  (s1_req_reg.fmt),
      .base (s1_req_reg.base),
      .imm  (s1_req_reg.imm),
      .inst (pack_inst),
      .err  (pack_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_reg <= 1'b0;
         s2_inst_reg  <= '0;
         s2_err_reg   <= 1'b0;
         s2_fmt_reg   <= '0;
      end else if (advance) begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            s2_inst_reg <= pack_inst;
            s2_err_reg  <= pack_err;
            s2_fmt_reg  <= s1_req_reg.fmt;
         end
      end
   end

   assign out_valid = s2_valid_reg;
   assign out_inst  = s2_inst_reg;
   assign out_err   = s2_err_reg;
   assign out_fmt   = s2_fmt_reg;

`ifdef IMM_ENC_ERR_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count <= '0;
      end else if (out_valid && out_ready && out_err && !(&err_count)) begin
         err_count <= err_count + CNT_W'(1);
      end
   end
`endif

endmodule
